ps_config_seq: RTL and testbench

//  Sequences Passive-Serial configuration of the board FPGA from the CPLD.

---
 rtl/tsxb_cfg_pkg.sv | 40 ++++
 rtl/ps_cfg_fifo.sv | 58 +++++
 rtl/ps_config_seq.sv | 242 ++++++++++++++++++++++++
 tb/tb_ps_config_seq.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tsxb_cfg_pkg.sv
// Shared definitions for the TSXB configuration block: FSM state encoding,
// error codes and the ZX-BUS port addresses that front this sequencer.
package tsxb_cfg_pkg;

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_NCFG    = 4'd1;
    localparam logic [3:0] S_WAIT_LO = 4'd2;
    localparam logic [3:0] S_WAIT_HI = 4'd3;
    localparam logic [3:0] S_LOAD    = 4'd4;
    localparam logic [3:0] S_SHIFT   = 4'd5;
    localparam logic [3:0] S_POST    = 4'd6;
    localparam logic [3:0] S_DONE    = 4'd7;
    localparam logic [3:0] S_ERR     = 4'd8;

    typedef enum logic [3:0] {
        ST_IDLE    = S_IDLE,
        ST_NCFG    = S_NCFG,
        ST_WAIT_LO = S_WAIT_LO,
        ST_WAIT_HI = S_WAIT_HI,
        ST_LOAD    = S_LOAD,
        ST_SHIFT   = S_SHIFT,
        ST_POST    = S_POST,
        ST_DONE    = S_DONE,
        ST_ERR     = S_ERR
    } cfg_state_t;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_NST_TMO  = 2'd1;
    localparam logic [1:0] ERR_NST_LOAD = 2'd2;
    localparam logic [1:0] ERR_ABORT    = 2'd3;

    localparam logic [15:0] CONF_PORT    = 16'hF0AF;
    localparam logic [7:0]  DATA_PORT_LO = 8'hAF;

    // A configuration cycle is in flight in every state except the three resting ones.
    function automatic logic is_busy_state(input cfg_state_t st);
        return !(st == ST_IDLE || st == ST_DONE || st == ST_ERR);
    endfunction

endpackage

// File: rtl/ps_cfg_fifo.sv
// Small first-word-fall-through byte FIFO buffering host-written bitstream data.
// A push while full is dropped and flagged; flush empties it in one cycle.
module ps_cfg_fifo #(
    parameter int FIFO_AW = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty,
    output logic       overflow
);

    localparam int DEPTH = 1 << FIFO_AW;

    logic [7:0]       mem [DEPTH];
    logic [FIFO_AW:0] wr_ptr;
    logic [FIFO_AW:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // The extra pointer bit distinguishes full from empty when the indices meet.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                      (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    assign do_push  = push && !full && !flush;
    assign do_pop   = pop && !empty && !flush;
    assign overflow = push && full && !flush;
    assign dout     = mem[rd_ptr[FIFO_AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[FIFO_AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps_config_seq.sv
// Passive-Serial configuration sequencer: drives nCONFIG and DCLK/DATA0 from
// buffered host bytes, supervises nSTATUS/CONF_DONE and reports completion or error.
import tsxb_cfg_pkg::*;

module ps_config_seq #(
    parameter int DCLK_DIV  = 1,
    parameter int NCFG_LOW  = 100,
    parameter int NST_TMO   = 4095,
    parameter int POST_CLKS = 16,
    parameter int FIFO_AW   = 2
) (
    input  logic       CLK50,
    input  logic       RST_N,
    input  logic       start,
    input  logic       abort,
    input  logic       wr_stb,
    input  logic [7:0] wr_data,
    output logic       wr_rdy,
    output logic       ncfg_low,
    input  logic       nstatus,
    input  logic       conf_done,
    output logic       pin_oe,
    output logic       dclk,
    output logic       data0,
    output logic       busy,
    output logic       done,
    output logic [1:0] err
);

    localparam int CNT_MAX = (NCFG_LOW > NST_TMO)
                           ? ((NCFG_LOW > DCLK_DIV) ? NCFG_LOW : DCLK_DIV)
                           : ((NST_TMO > DCLK_DIV) ? NST_TMO : DCLK_DIV);
    localparam int CNT_W = $clog2(CNT_MAX + 1);
    localparam int PC_W  = $clog2(POST_CLKS + 1);

    localparam logic [CNT_W-1:0] NCFG_LAST = CNT_W'(NCFG_LOW - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(NST_TMO - 1);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DCLK_DIV - 1);
    localparam logic [PC_W-1:0]  POST_LAST = PC_W'(POST_CLKS - 1);

    cfg_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [PC_W-1:0]  post_cnt;
    logic [2:0]       bit_cnt;
    logic [6:0]       shreg;
    logic [1:0]       nst_sync;
    logic [1:0]       cd_sync;
    logic             nstatus_s;
    logic             conf_done_s;
    logic             ovf_sticky;

    logic [7:0]       fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_ovf;
    logic             fifo_flush;
    logic             fifo_pop;

    logic             can_start;
    logic             kill;
    logic             nst_fail;
    logic             tmo_hit;
    logic             err_go;
    logic [1:0]       err_code;
    logic             div_end;

    always_ff @(posedge CLK50 or negedge RST_N) begin
        if (!RST_N) begin
            nst_sync <= '0;
            cd_sync  <= '0;
        end else begin
            nst_sync <= {nst_sync[0], nstatus};
            cd_sync  <= {cd_sync[0], conf_done};
        end
    end

    assign nstatus_s   = nst_sync[1];
    assign conf_done_s = cd_sync[1];

    // Error sources in priority order: abort/overflow, nSTATUS drop while loading, timeout.
    assign can_start = start && !is_busy_state(state);
    assign kill      = (abort && state != ST_IDLE) ||
                       ((ovf_sticky || fifo_ovf) && is_busy_state(state));
    assign nst_fail  = !nstatus_s &&
                       (state == ST_LOAD || state == ST_SHIFT || state == ST_POST);
    assign tmo_hit   = (state == ST_WAIT_HI) && !nstatus_s && (cnt == TMO_LAST);
    assign err_go    = kill || nst_fail || tmo_hit;
    assign err_code  = kill ? ERR_ABORT : (nst_fail ? ERR_NST_LOAD : ERR_NST_TMO);
    assign div_end   = (cnt == DIV_LAST);

    assign fifo_flush = can_start && !kill;
    assign fifo_pop   = (state == ST_LOAD) && !err_go && !conf_done_s && !fifo_empty;
    assign wr_rdy     = !fifo_full;

    always_ff @(posedge CLK50 or negedge RST_N) begin
        if (!RST_N) begin
            ovf_sticky <= 1'b0;
        end else if (fifo_flush) begin
            ovf_sticky <= 1'b0;
        end else if (fifo_ovf) begin
            ovf_sticky <= 1'b1;
        end
    end

    always_ff @(posedge CLK50 or negedge RST_N) begin
        if (!RST_N) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            post_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            ncfg_low <= 1'b0;
            pin_oe   <= 1'b0;
            dclk     <= 1'b0;
            data0    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= ERR_NONE;
        end else if (err_go) begin
            state    <= ST_ERR;
            err      <= err_code;
            ncfg_low <= 1'b0;
            pin_oe   <= 1'b0;
            dclk     <= 1'b0;
            data0    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (can_start) begin
                        state    <= ST_NCFG;
                        cnt      <= '0;
                        ncfg_low <= 1'b1;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        err      <= ERR_NONE;
                    end
                end
                ST_NCFG: begin
                    if (cnt == NCFG_LAST) begin
                        state <= ST_WAIT_LO;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_WAIT_LO: begin
                    if (!nstatus_s) begin
                        state    <= ST_WAIT_HI;
                        ncfg_low <= 1'b0;
                        pin_oe   <= 1'b1;
                        dclk     <= 1'b0;
                        cnt      <= '0;
                    end
                end
                ST_WAIT_HI: begin
                    if (nstatus_s) begin
                        state <= ST_LOAD;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_LOAD: begin
                    dclk <= 1'b0;
                    if (conf_done_s) begin
                        state    <= ST_POST;
                        data0    <= 1'b0;
                        cnt      <= '0;
                        post_cnt <= '0;
                    end else if (!fifo_empty) begin
                        state   <= ST_SHIFT;
                        shreg   <= fifo_dout[7:1];
                        data0   <= fifo_dout[0];
                        bit_cnt <= '0;
                        cnt     <= '0;
                    end
                end
                // Each bit: DCLK_DIV cycles low with data stable, then DCLK_DIV high.
                ST_SHIFT: begin
                    if (!div_end) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        cnt <= '0;
                        if (!dclk) begin
                            dclk <= 1'b1;
                        end else begin
                            dclk <= 1'b0;
                            if (bit_cnt == 3'd7) begin
                                state <= ST_LOAD;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                                data0   <= shreg[0];
                                shreg   <= {1'b0, shreg[6:1]};
                            end
                        end
                    end
                end
                ST_POST: begin
                    if (!div_end) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        cnt <= '0;
                        if (!dclk) begin
                            dclk <= 1'b1;
                        end else begin
                            dclk <= 1'b0;
                            if (post_cnt == POST_LAST) begin
                                state  <= ST_DONE;
                                done   <= 1'b1;
                                pin_oe <= 1'b0;
                                busy   <= 1'b0;
                            end else begin
                                post_cnt <= post_cnt + 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    ps_cfg_fifo #(
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .clk      (CLK50),
        .rst_n    (RST_N),
        .flush    (fifo_flush),
        .push     (wr_stb),
        .din      (wr_data),
        .pop      (fifo_pop),
        .dout     (fifo_dout),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .overflow (fifo_ovf)
    );

endmodule

// File: tb/tb_ps_config_seq.sv
// Bench for ps_config_seq: a simple FPGA pin model plus a bit-level scoreboard
// that expects every accepted byte to appear LSB-first on DATA0 at DCLK rises.
module tb_ps_config_seq;

    logic       CLK50 = 1'b0;
    logic       RST_N = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       wr_stb = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       nstatus = 1'b1;
    logic       conf_done = 1'b0;
    logic       wr_rdy;
    logic       ncfg_low;
    logic       pin_oe;
    logic       dclk;
    logic       data0;
    logic       busy;
    logic       done;
    logic [1:0] err;

    int   checks = 0;
    int   errors = 0;
    logic q [$];
    logic exp_bit;
    logic dclk_prev = 1'b0;
    int   cyc = 0;
    int   last_rise = 0;
    int   bit_idx = 0;
    int   post_rises = 0;
    bit   post_mode = 1'b0;

    ps_config_seq #(
        .DCLK_DIV  (1),
        .NCFG_LOW  (100),
        .NST_TMO   (100),
        .POST_CLKS (16),
        .FIFO_AW   (2)
    ) dut (
        .CLK50     (CLK50),
        .RST_N     (RST_N),
        .start     (start),
        .abort     (abort),
        .wr_stb    (wr_stb),
        .wr_data   (wr_data),
        .wr_rdy    (wr_rdy),
        .ncfg_low  (ncfg_low),
        .nstatus   (nstatus),
        .conf_done (conf_done),
        .pin_oe    (pin_oe),
        .dclk      (dclk),
        .data0     (data0),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 CLK50 = ~CLK50;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Scoreboard: pop one expected bit per DCLK rise while driving pins.
    always @(negedge CLK50) begin
        cyc++;
        if (RST_N && pin_oe && dclk && !dclk_prev) begin
            if (q.size() > 0) begin
                exp_bit = q.pop_front();
                checkOutput("data0_bit", data0, exp_bit);
                if (bit_idx != 0) begin
                    checkOutput("dclk_period", cyc - last_rise, 2);
                end
                last_rise = cyc;
                bit_idx = (bit_idx + 1) % 8;
            end else if (post_mode) begin
                post_rises++;
            end else begin
                checkOutput("spurious_dclk_rise", dclk, 0);
            end
        end
        dclk_prev = dclk;
    end

    task automatic applyStimulus(input logic [7:0] b, input bit accept);
        @(posedge CLK50); #1;
        wr_data = b;
        wr_stb  = 1'b1;
        if (accept) begin
            for (int i = 0; i < 8; i++) q.push_back(b[i]);
        end
        @(posedge CLK50); #1;
        wr_stb = 1'b0;
    endtask

    task automatic startCycle();
        q.delete();
        bit_idx = 0;
        @(posedge CLK50); #1 start = 1'b1;
        @(posedge CLK50); #1 start = 1'b0;
    endtask

    task automatic fpgaHandshake(input bit rise);
        int n;
        n = 0;
        while (ncfg_low !== 1'b1 && n < 20) begin @(posedge CLK50); #1; n++; end
        checkOutput("ncfg_asserted", ncfg_low, 1);
        repeat (5) @(posedge CLK50);
        #1 nstatus = 1'b0;
        n = 0;
        while (ncfg_low !== 1'b0 && n < 300) begin @(posedge CLK50); #1; n++; end
        checkOutput("ncfg_released", ncfg_low, 0);
        if (rise) begin
            repeat (40) @(posedge CLK50);
            #1 nstatus = 1'b1;
        end
    endtask

    task automatic waitQueue(input int lvl, input string tag);
        int n;
        n = 0;
        while (q.size() > lvl && n < 400) begin @(posedge CLK50); #1; n++; end
        checkOutput(tag, q.size(), lvl);
    endtask

    task automatic runPost(input string pfx);
        int n;
        post_rises = 0;
        post_mode  = 1'b1;
        conf_done  = 1'b1;
        n = 0;
        while (done !== 1'b1 && n < 300) begin @(posedge CLK50); #1; n++; end
        checkOutput({pfx, "_done"}, done, 1);
        checkOutput({pfx, "_post_rises"}, post_rises, 16);
        checkOutput({pfx, "_pin_oe"}, pin_oe, 0);
        checkOutput({pfx, "_busy"}, busy, 0);
        checkOutput({pfx, "_err"}, err, 0);
        post_mode = 1'b0;
        conf_done = 1'b0;
    endtask

    task automatic checkResetValues(input string pfx);
        checkOutput({pfx, "_ncfg_low"}, ncfg_low, 0);
        checkOutput({pfx, "_pin_oe"}, pin_oe, 0);
        checkOutput({pfx, "_dclk"}, dclk, 0);
        checkOutput({pfx, "_data0"}, data0, 0);
        checkOutput({pfx, "_busy"}, busy, 0);
        checkOutput({pfx, "_done"}, done, 0);
        checkOutput({pfx, "_err"}, err, 0);
        checkOutput({pfx, "_wr_rdy"}, wr_rdy, 1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        repeat (3) @(posedge CLK50);
        #1;
        checkResetValues("reset");
        RST_N = 1'b1;
        repeat (2) @(posedge CLK50);

        $display("[TB] single byte A5, nSTATUS handshake");
        startCycle();
        checkOutput("start_busy", busy, 1);
        applyStimulus(8'hA5, 1);
        fpgaHandshake(1);
        waitQueue(0, "a5_drained");

        $display("[TB] three bytes then FIFO stall");
        applyStimulus(8'h3C, 1);
        applyStimulus(8'h96, 1);
        applyStimulus(8'h0F, 1);
        waitQueue(0, "three_drained");
        repeat (50) @(posedge CLK50);
        #1;
        checkOutput("stall_dclk", dclk, 0);
        checkOutput("stall_busy", busy, 1);
        applyStimulus(8'hF0, 1);
        waitQueue(0, "resume_drained");

        $display("[TB] conf_done and init clocks");
        runPost("post1");

        $display("[TB] nSTATUS timeout");
        startCycle();
        fpgaHandshake(0);
        n = 0;
        while (err === 2'd0 && n < 300) begin @(posedge CLK50); #1; n++; end
        checkOutput("tmo_err", err, 1);
        checkOutput("tmo_cycles_ok", (n >= 98 && n <= 102), 1);
        checkOutput("tmo_pin_oe", pin_oe, 0);
        checkOutput("tmo_ncfg", ncfg_low, 0);
        checkOutput("tmo_busy", busy, 0);

        $display("[TB] nSTATUS drop mid-byte");
        startCycle();
        fpgaHandshake(1);
        applyStimulus(8'h33, 1);
        applyStimulus(8'hCC, 1);
        waitQueue(13, "nst_midbyte_reached");
        nstatus = 1'b0;
        n = 0;
        while (err !== 2'd2 && n < 10) begin @(posedge CLK50); #1; n++; end
        checkOutput("nst_load_err", err, 2);
        checkOutput("nst_load_latency_ok", (n <= 3), 1);
        checkOutput("nst_load_pin_oe", pin_oe, 0);
        nstatus = 1'b1;

        $display("[TB] FIFO overflow");
        startCycle();
        for (int i = 0; i < 4; i++) applyStimulus(8'h10 + 8'(i), 1);
        checkOutput("full_wr_rdy", wr_rdy, 0);
        checkOutput("full_no_err_yet", err, 0);
        applyStimulus(8'hEE, 0);
        n = 0;
        while (err === 2'd0 && n < 10) begin @(posedge CLK50); #1; n++; end
        checkOutput("ovf_err", err, 3);
        checkOutput("ovf_busy", busy, 0);
        checkOutput("ovf_ncfg", ncfg_low, 0);

        $display("[TB] abort mid-shift");
        startCycle();
        checkOutput("flush_wr_rdy", wr_rdy, 1);
        fpgaHandshake(1);
        applyStimulus(8'hC3, 1);
        waitQueue(4, "abort_midbyte_reached");
        @(posedge CLK50); #1 abort = 1'b1;
        @(posedge CLK50); #1 abort = 1'b0;
        checkOutput("abort_err", err, 3);
        checkOutput("abort_pin_oe", pin_oe, 0);
        checkOutput("abort_dclk", dclk, 0);

        $display("[TB] asynchronous reset mid-shift");
        startCycle();
        fpgaHandshake(1);
        applyStimulus(8'h5A, 1);
        waitQueue(5, "rst_midbyte_reached");
        @(posedge CLK50);
        #3 RST_N = 1'b0;
        #1;
        checkResetValues("async_rst");
        q.delete();
        repeat (2) @(posedge CLK50);
        #1 RST_N = 1'b1;
        repeat (2) @(posedge CLK50);

        $display("[TB] clean cycle after reset");
        startCycle();
        fpgaHandshake(1);
        applyStimulus(8'h81, 1);
        applyStimulus(8'h7E, 1);
        waitQueue(0, "clean_drained");
        runPost("post2");

        repeat (3) @(posedge CLK50);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
